serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: computes diff = a - b - borrow_in over WIDTH cycles, LSB first.

---
 rtl/subtractor_pkg.sv | 15 +
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and width limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package subtractor_pkg;

  // Widest operand the serial datapath is meant to be configured for.
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - borrowIn.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b       in   operand bits (minuend, subtrahend)
//   borrowIn   in   borrow from the next-lower bit
//   diff       out  difference bit
//   borrowOut  out  borrow into the next-higher bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrowIn,
  output logic diff,
  output logic borrowOut
);

  assign diff      = a ^ b ^ borrowIn;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow is already pending.
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in (mod 2^WIDTH), one bit per clock, LSB first.
// Latency: WIDTH shift cycles after the accepting edge; result valid with a one-cycle done pulse.
// Backpressure: start is only accepted while idle or in the done cycle; ignored while busy.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request, sampled when busy=0
//   a, b, borrow_in         operands, captured on the accepting edge
//   busy                    high while bits are being processed
//   done                    one-cycle pulse, diff/borrow_out valid
//   diff, borrow_out        registered result, held until the next done
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range 2..MAX_WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bor;
  logic [CNT_W-1:0] cnt;

  logic             d;
  logic             bnext;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_fs (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .borrowIn  (bor),
    .diff      (d),
    .borrowOut (bnext)
  );

  // Result bits arrive LSB first, so each new bit enters at the top and
  // the register ends up aligned after WIDTH shifts.
  assign res_next = {d, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bor   <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bor    <= bnext;
          if (cnt == LAST) begin
            // Final bit: publish the result on the same edge so diff never
            // shows a partially shifted value.
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bnext;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back request: skip IDLE entirely.
            a_sr  <= a;
            b_sr  <= b;
            bor   <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=3.
// Expected results come from an integer reference pushed to a scoreboard at start.
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] diff;
    logic       bo;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       start8, bi8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;

  logic       start3, bi3, busy3, done3, bo3;
  logic [2:0] a3, b3, diff3;

  exp_t sb8[$];
  exp_t sb3[$];

  int passed = 0;
  int total  = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .borrow_in(bi3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus / scoreboard helpers (no checks) ----------------
  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic biv);
    exp_t e;
    int   r;
    r      = int'(av) - int'(bv) - int'(biv);
    e.diff = r[7:0];
    e.bo   = (int'(av) < int'(bv) + int'(biv));
    sb8.push_back(e);
    a8 = av; b8 = bv; bi8 = biv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom_range(0, 1));
  endtask

  task automatic start_op3(input logic [2:0] av, input logic [2:0] bv, input logic biv);
    exp_t e;
    int   r;
    r      = int'(av) - int'(bv) - int'(biv);
    e.diff = {5'd0, r[2:0]};
    e.bo   = (int'(av) < int'(bv) + int'(biv));
    sb3.push_back(e);
    a3 = av; b3 = bv; bi3 = biv; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom); bi3 = 1'($urandom_range(0, 1));
  endtask

  task automatic pop8(output exp_t e);
    if (sb8.size() != 0) e = sb8.pop_front();
    else e = 'x;
  endtask

  task automatic pop3(output exp_t e);
    if (sb3.size() != 0) e = sb3.pop_front();
    else e = 'x;
  endtask

  // Called right after the accepting edge. Returns edges until done is seen,
  // the number of sampled cycles with busy high, and whether diff moved early.
  task automatic wait_done8(output bit ok, output int cycles, output int busy_cnt,
                            output bit diff_moved);
    logic [7:0] d0;
    d0 = diff8; ok = 1'b0; cycles = 0; diff_moved = 1'b0;
    busy_cnt = busy8 ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        ok = 1'b1; cycles = n;
        break;
      end
      if (busy8) busy_cnt++;
      if (diff8 !== d0) diff_moved = 1'b1;
    end
  endtask

  task automatic wait_done3(output bit ok, output int cycles);
    ok = 1'b0; cycles = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done3) begin
        ok = 1'b1; cycles = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 0; a8 = 8'hA5; b8 = 8'h5A; bi8 = 1;
    start3 = 0; a3 = 3'd5;  b3 = 3'd2;  bi3 = 1;
    #3;
    total++; if (busy8 !== 1'b0) $display("FAIL reset_busy8: got %b want 0", busy8); else passed++;
    total++; if (done8 !== 1'b0) $display("FAIL reset_done8: got %b want 0", done8); else passed++;
    total++; if (diff8 !== 8'd0) $display("FAIL reset_diff8: got %h want 00", diff8); else passed++;
    total++; if (bo8 !== 1'b0) $display("FAIL reset_borrow8: got %b want 0", bo8); else passed++;
    total++; if ({busy3, done3, diff3, bo3} !== 6'd0)
      $display("FAIL reset_dut3: got %b want 000000", {busy3, done3, diff3, bo3}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit ok, mv; int cyc, bc; exp_t e;
    start_op8(8'd5, 8'd3, 1'b0);
    wait_done8(ok, cyc, bc, mv);
    total++; if (!ok) $display("FAIL basic_done_seen: got timeout want done"); else passed++;
    total++; if (cyc != 8) $display("FAIL basic_latency: got %0d want 8", cyc); else passed++;
    total++; if (mv) $display("FAIL basic_diff_stable: got change during shift want none"); else passed++;
    pop8(e);
    total++; if (diff8 !== e.diff) $display("FAIL basic_diff: got %h want %h", diff8, e.diff); else passed++;
    total++; if (bo8 !== e.bo) $display("FAIL basic_borrow: got %b want %b", bo8, e.bo); else passed++;
    total++; if (diff8 !== 8'd2) $display("FAIL basic_diff_value: got %h want 02", diff8); else passed++;
    @(posedge clk); #1;
    total++; if (done8 !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done8); else passed++;
    total++; if (diff8 !== 8'd2) $display("FAIL basic_hold: got %h want 02", diff8); else passed++;
  endtask

  task automatic test_borrow;
    bit ok, mv; int cyc, bc; exp_t e;
    start_op8(8'd3, 8'd5, 1'b0);
    wait_done8(ok, cyc, bc, mv);
    total++; if (!ok) $display("FAIL borrow_done_seen: got timeout want done"); else passed++;
    total++; if (bc != 8) $display("FAIL borrow_busy_cycles: got %0d want 8", bc); else passed++;
    total++; if (busy8 !== 1'b0) $display("FAIL borrow_busy_at_done: got %b want 0", busy8); else passed++;
    pop8(e);
    total++; if (diff8 !== e.diff) $display("FAIL borrow_diff: got %h want %h", diff8, e.diff); else passed++;
    total++; if (bo8 !== e.bo) $display("FAIL borrow_flag: got %b want %b", bo8, e.bo); else passed++;
    total++; if ({diff8, bo8} !== {8'hFE, 1'b1})
      $display("FAIL borrow_value: got %h/%b want fe/1", diff8, bo8); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bit ok, mv; int cyc, bc; exp_t e;
    start_op8(8'd0, 8'd0, 1'b1);
    wait_done8(ok, cyc, bc, mv);
    total++; if (!ok) $display("FAIL b2b_first_done: got timeout want done"); else passed++;
    pop8(e);
    total++; if ({diff8, bo8} !== {e.diff, e.bo})
      $display("FAIL b2b_first_result: got %h/%b want %h/%b", diff8, bo8, e.diff, e.bo); else passed++;
    // Request during the done cycle: must be accepted on the very next edge.
    start_op8(8'd255, 8'd255, 1'b0);
    total++; if (busy8 !== 1'b1) $display("FAIL b2b_no_gap: got busy=%b want 1", busy8); else passed++;
    wait_done8(ok, cyc, bc, mv);
    total++; if (cyc != 8) $display("FAIL b2b_latency: got %0d want 8", cyc); else passed++;
    pop8(e);
    total++; if ({diff8, bo8} !== {e.diff, e.bo})
      $display("FAIL b2b_second_result: got %h/%b want %h/%b", diff8, bo8, e.diff, e.bo); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    bit ok, mv; int cyc, bc, extra; exp_t e;
    start_op8(8'd200, 8'd17, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'd9; b8 = 8'd1; bi8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(ok, cyc, bc, mv);
    total++; if (!ok || cyc != 5) $display("FAIL ignore_latency: got ok=%b cycles=%0d want 1/5", ok, cyc); else passed++;
    pop8(e);
    total++; if ({diff8, bo8} !== {e.diff, e.bo})
      $display("FAIL ignore_result: got %h/%b want %h/%b", diff8, bo8, e.diff, e.bo); else passed++;
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    total++; if (extra != 0) $display("FAIL ignore_single_done: got %0d extra pulses want 0", extra); else passed++;
    total++; if (diff8 !== 8'd182) $display("FAIL ignore_hold: got %h want b6", diff8); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok, mv; int cyc, bc; exp_t e;
    start_op8(8'd100, 8'd50, 1'b0);
    sb8.delete();  // this operation is aborted by reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (busy8 !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy8); else passed++;
    total++; if (done8 !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done8); else passed++;
    total++; if ({diff8, bo8} !== 9'd0) $display("FAIL rstmid_result: got %h/%b want 00/0", diff8, bo8); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op8(8'd100, 8'd50, 1'b0);
    wait_done8(ok, cyc, bc, mv);
    total++; if (!ok || cyc != 8) $display("FAIL rstmid_recover: got ok=%b cycles=%0d want 1/8", ok, cyc); else passed++;
    pop8(e);
    total++; if ({diff8, bo8} !== {e.diff, e.bo})
      $display("FAIL rstmid_result2: got %h/%b want %h/%b", diff8, bo8, e.diff, e.bo); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive3;
    bit ok; int cyc; exp_t e;
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          start_op3(3'(ai), 3'(bi), 1'(ci));
          wait_done3(ok, cyc);
          pop3(e);
          total++;
          if (!ok || cyc != 3 || diff3 !== e.diff[2:0] || bo3 !== e.bo)
            $display("FAIL exh3 a=%0d b=%0d bin=%0d: got ok=%b cyc=%0d diff=%0d bo=%b want cyc=3 diff=%0d bo=%b",
                     ai, bi, ci, ok, cyc, diff3, bo3, e.diff[2:0], e.bo);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
